// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Reset clears only the output register; stored words survive reset.
module sync_ram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] Din,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  writeEn,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] Dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // No reset on the array: contents must persist, and rst_n only blocks the write
  always_ff @(posedge clk) begin
    if (rst_n && writeEn) begin
      mem[addr] <= Din;
    end
  end

  // Write-first: a simultaneous read returns the incoming data, not the old word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dout <= '0;
    end else if (read && writeEn) begin
      Dout <= Din;
    end else if (read) begin
      Dout <= mem[addr];
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
// Self-checking bench for sync_ram: a bench-side memory model feeds a queue of
// expected read data that is compared one edge after each read is issued.
module tb_sync_ram;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] Din;
  logic [AW-1:0] addr;
  logic          writeEn;
  logic          read;
  logic [DW-1:0] Dout;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] expQ [$];
  int            addrList [$];

  sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Din(Din),
    .addr(addr),
    .writeEn(writeEn),
    .read(read),
    .Dout(Dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge
  task automatic applyWrite(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = AW'(a); Din = d; writeEn = 1'b1; read = 1'b0;
    @(posedge clk); #1;
    if (rst_n) model[a] = d;
    writeEn = 1'b0;
  endtask

  task automatic applyRead(input int a);
    @(negedge clk);
    addr = AW'(a); writeEn = 1'b0; read = 1'b1;
    expQ.push_back(model.exists(a) ? model[a] : {DW{1'bx}});
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic applyWriteRead(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = AW'(a); Din = d; writeEn = 1'b1; read = 1'b1;
    expQ.push_back(d);
    @(posedge clk); #1;
    model[a] = d;
    writeEn = 1'b0; read = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] exp;
    rst_n = 1'b0; Din = '0; addr = '0; writeEn = 1'b0; read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp = '0;
    checks++;
    if (Dout !== exp) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %h expected %h", Dout, exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_readback();
    logic [DW-1:0] exp;
    for (int i = 0; i < (1 << AW); i++) begin
      if (i < 512 || i >= 65024 || (i % 61) == 0) addrList.push_back(i);
    end
    foreach (addrList[k]) applyWrite(addrList[k], DW'(2 * addrList[k] + 1));
    foreach (addrList[k]) begin
      applyRead(addrList[k]);
      exp = expQ.pop_front();
      checks++;
      if (Dout !== exp || Dout !== DW'(2 * addrList[k] + 1)) begin
        errors++;
        $display("[TB] FAIL fill_readback addr %0d: got %h expected %h", addrList[k], Dout, exp);
      end
    end
  endtask

  task automatic test_hold();
    logic [DW-1:0] exp;
    applyRead(5);
    exp = expQ.pop_front();
    checks++;
    if (Dout !== exp) begin
      errors++;
      $display("[TB] FAIL hold_read5: got %h expected %h", Dout, exp);
    end
    @(negedge clk);
    addr = AW'(7); read = 1'b0; writeEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Dout !== 32'd11) begin
      errors++;
      $display("[TB] FAIL hold_idle: got %h expected %h", Dout, 32'd11);
    end
    applyWrite(7, 32'd15);
    checks++;
    if (Dout !== 32'd11) begin
      errors++;
      $display("[TB] FAIL hold_during_write: got %h expected %h", Dout, 32'd11);
    end
  endtask

  task automatic test_write_first();
    logic [DW-1:0] exp;
    applyWriteRead(3, 32'hDEADBEEF);
    exp = expQ.pop_front();
    checks++;
    if (Dout !== exp) begin
      errors++;
      $display("[TB] FAIL write_first_same_edge: got %h expected %h", Dout, exp);
    end
    applyRead(0);
    void'(expQ.pop_front());
    applyRead(3);
    exp = expQ.pop_front();
    checks++;
    if (Dout !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_first_readback: got %h expected %h", Dout, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp;
    applyRead(5);
    void'(expQ.pop_front());
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Dout !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async_dout: got %h expected %h", Dout, 32'd0);
    end
    applyWrite(9, 32'd0);
    checks++;
    if (Dout !== '0) begin
      errors++;
      $display("[TB] FAIL reset_hold_dout: got %h expected %h", Dout, 32'd0);
    end
    #2;
    rst_n = 1'b1;
    applyRead(5);
    exp = expQ.pop_front();
    checks++;
    if (Dout !== exp || Dout !== 32'd11) begin
      errors++;
      $display("[TB] FAIL reset_keeps_contents: got %h expected %h", Dout, exp);
    end
    applyRead(9);
    exp = expQ.pop_front();
    checks++;
    if (Dout !== 32'd19) begin
      errors++;
      $display("[TB] FAIL reset_blocks_write: got %h expected %h", Dout, exp);
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] exp;
    int probe [4] = '{65535, 0, 65534, 1};
    applyWrite(65535, 32'hFFFFFFFF);
    applyWrite(0, 32'h00000000);
    foreach (probe[k]) begin
      applyRead(probe[k]);
      exp = expQ.pop_front();
      checks++;
      if (Dout !== exp) begin
        errors++;
        $display("[TB] FAIL boundary addr %0d: got %h expected %h", probe[k], Dout, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    int a;
    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 65535));
      applyWrite(a, DW'($urandom));
      applyRead(a);
      exp = expQ.pop_front();
      checks++;
      if (Dout !== exp) begin
        errors++;
        $display("[TB] FAIL back_to_back addr %0d: got %h expected %h", a, Dout, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_hold();
    test_write_first();
    test_reset_mid();
    test_boundary();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_ram.md
SYNC_RAM -- requirements
Module: sync_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: address width; depth SHALL be 2**ADDR_WIDTH words (65536 at default).
REQ-002 Parameter DATA_WIDTH, default 32: word width in bits.
REQ-003 Port clk, input, 1: single clock; all state changes SHALL occur on the rising edge, except reset.
REQ-004 Port rst_n, input, 1: reset; one clock; reset is asynchronous and active-low.
REQ-005 Port Din, input, DATA_WIDTH: write data.
REQ-006 Port addr, input, ADDR_WIDTH: word address, shared by read and write.
REQ-007 Port writeEn, input, 1: write enable, active-high.
REQ-008 Port read, input, 1: read enable, active-high.
REQ-009 Port Dout, output, DATA_WIDTH: registered read data.

Function
REQ-010 Storage SHALL be a single-port array of 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-011 Write: at rising clk with rst_n=1 and writeEn=1, mem[addr] SHALL take Din.
REQ-012 Writes SHALL complete in one cycle; the new value SHALL be readable from the next edge onward.
REQ-013 Read: at rising clk with rst_n=1, read=1 and writeEn=0, Dout SHALL take mem[addr].
REQ-014 Read latency: Dout SHALL be valid immediately after the rising edge that samples addr and read, i.e. 1 cycle.
REQ-015 Simultaneous write and read: write-first; mem[addr] and Dout SHALL both take Din on that edge.
REQ-016 With read=0 and writeEn=0, Dout SHALL hold its previous value and memory SHALL be unchanged.
REQ-017 With read=0 and writeEn=1, Dout SHALL hold its previous value.
REQ-018 Dout SHALL never change combinationally with addr, Din, read or writeEn.
REQ-019 Every address from 0 to 2**ADDR_WIDTH-1 SHALL be accessible.
REQ-020 There SHALL be no wrap-around or aliasing; the full address range maps 1:1 to words.
REQ-021 Words SHALL be stored and returned unmodified at the full DATA_WIDTH.
REQ-022 There SHALL be no truncation or sign handling of stored words.
REQ-023 Memory contents are undefined at power-up; reading an unwritten word SHALL return an unspecified value, X in simulation.

Reset
REQ-024 While rst_n=0, Dout SHALL be 0, asynchronously on the falling rst_n.
REQ-025 While rst_n=0, writes and reads SHALL be suppressed.
REQ-026 Reset SHALL NOT clear memory contents; words written before reset SHALL remain readable after rst_n returns high.
REQ-027 Reset asserted mid-operation SHALL abort any write on that edge, leaving the addressed word unchanged.
REQ-028 The first rising clk with rst_n=1 SHALL operate normally.

Verification
REQ-029 Fill/readback: write mem[i]=2i+1 for all i in 0..65535 with writeEn=1, read=0; then read each i with writeEn=0, read=1 -> Dout=2i+1 one edge after addr i is applied (e.g. i=0 -> 1, i=65535 -> 131071).
REQ-030 Hold: after reading addr 5 (Dout=11), set read=0 and change addr to 7 -> Dout stays 11.
REQ-031 Write-first: with mem[3]=7, set writeEn=1, read=1, addr=3, Din=0xDEADBEEF -> Dout=0xDEADBEEF on that edge; a later read of addr 3 also returns 0xDEADBEEF.
REQ-032 Reset: with Dout=11, drive rst_n=0 between edges -> Dout=0 immediately; after release, read addr 5 -> Dout=11 (contents kept).
REQ-033 Reset blocks write: with rst_n=0, writeEn=1, addr=9, Din=0 -> after release, read addr 9 returns the prior value 19.
REQ-034 Boundary: write 0xFFFFFFFF to addr 0xFFFF and 0x00000000 to addr 0 -> reads return exactly those values and neighbouring addresses are unchanged.
